// File: rtl/multicycle_rv_core_if.sv
// Memory bus between multicycle_rv_core and its unified word-addressed BRAM.
// The core drives address/write side combinationally; the memory returns
// read data one cycle after it samples memaddr.
interface multicycle_rv_core_if #(
  parameter int ADDR_W = 8
);
  logic              memwe;
  logic [ADDR_W-1:0] memaddr;
  logic [31:0]       memdin;
  logic [31:0]       memdout;

  modport master (output memwe, output memaddr, output memdin, input memdout);
  modport slave  (input memwe, input memaddr, input memdin, output memdout);
endinterface

// File: rtl/multicycle_rv_core.sv
// Multicycle RV32I-subset core (LW, SW, ADDI, ADD, SUB, BEQ, BNE, BLT, JAL).
// Anything else, including ECALL, parks the core in a sticky HALT.
// Optional retired-instruction counter: define MULTICYCLE_RV_CORE_INSTRET_EN.
//
// state  | meaning
// FETCH  | present pc word address to memory
// IRLD   | capture instruction from memory
// DEC    | read rs1/rs2, reject unsupported encodings
// EXEC   | ALU / address calc / branch resolve / JAL link
// MEM    | LW address out, or SW write strobe
// MWAIT  | capture load data
// WB     | register write-back, advance pc
// HALT   | terminal until rst
module multicycle_rv_core #(
  parameter int ADDR_W = 8,
  parameter int NREG   = 32,
  parameter int A0_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_rv_core_if.master mem,
  output logic [A0_W-1:0]     a0out,
  output logic                halted,
  output logic [31:0]         instret
);
  localparam int PW = ADDR_W + 2;
  localparam int RW = $clog2(NREG);

  typedef enum logic [2:0] {
    S_FETCH, S_IRLD, S_DEC, S_EXEC, S_MEM, S_MWAIT, S_WB, S_HALT
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] pc;
  logic [31:0]   instr, reg_a, reg_b, aluout, data;
  logic [31:0]   xreg [NREG];

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, alu_res;
  logic        is_lw, is_sw, is_addi, is_add, is_sub, is_beq, is_bne, is_blt;
  logic        is_br, is_jal, legal, regs_ok, br_taken;
  logic [PW-1:0] pc_plus4, pc_br, pc_jal;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign is_lw   = (opcode == 7'b0000011) && (funct3 == 3'b010);
  assign is_sw   = (opcode == 7'b0100011) && (funct3 == 3'b010);
  assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_add  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign is_sub  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
  assign is_beq  = (opcode == 7'b1100011) && (funct3 == 3'b000);
  assign is_bne  = (opcode == 7'b1100011) && (funct3 == 3'b001);
  assign is_blt  = (opcode == 7'b1100011) && (funct3 == 3'b100);
  assign is_br   = is_beq | is_bne | is_blt;
  assign is_jal  = (opcode == 7'b1101111);
  assign legal   = is_lw | is_sw | is_addi | is_add | is_sub | is_br | is_jal;

  function automatic logic reg_in_range(input logic [4:0] r);
    return 32'(r) < NREG;
  endfunction

  // Only the register fields an instruction actually uses are range-checked
  // (matters for the 16-register RV32E build).
  assign regs_ok =
    !((is_lw | is_addi | is_add | is_sub | is_jal) && !reg_in_range(rd)) &&
    !((is_lw | is_sw | is_addi | is_add | is_sub | is_br) && !reg_in_range(rs1)) &&
    !((is_sw | is_add | is_sub | is_br) && !reg_in_range(rs2));

  function automatic logic [31:0] rd_reg(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : xreg[r[RW-1:0]];
  endfunction

  assign alu_res  = is_add ? reg_a + reg_b :
                    is_sub ? reg_a - reg_b :
                    is_sw  ? reg_a + imm_s :
                             reg_a + imm_i;
  assign br_taken = is_beq ? (reg_a == reg_b) :
                    is_bne ? (reg_a != reg_b) :
                             ($signed(reg_a) < $signed(reg_b));
  assign pc_plus4 = pc + PW'(4);
  assign pc_br    = PW'(32'(pc) + imm_b);
  assign pc_jal   = PW'(32'(pc) + imm_j);

  assign halted = (state == S_HALT);
  assign a0out  = xreg[10][A0_W-1:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  // Next-state and memory-bus outputs; bus idles on the pc word address.
  always_comb begin
    state_nx    = state;
    mem.memwe   = 1'b0;
    mem.memaddr = pc[PW-1:2];
    mem.memdin  = 32'd0;
    case (state)
      S_FETCH: state_nx = S_IRLD;
      S_IRLD:  state_nx = S_DEC;
      S_DEC:   state_nx = (legal && regs_ok) ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_br)              state_nx = S_FETCH;
        else if (is_lw | is_sw) state_nx = S_MEM;
        else                    state_nx = S_WB;
      end
      S_MEM: begin
        mem.memaddr = aluout[PW-1:2];
        if (is_sw) begin
          mem.memwe  = 1'b1;
          mem.memdin = reg_b;
          state_nx   = S_FETCH;
        end else begin
          state_nx = S_MWAIT;
        end
      end
      S_MWAIT: state_nx = S_WB;
      S_WB:    state_nx = S_FETCH;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_HALT;
    endcase
  end

  // Datapath registers, pc and register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= '0;
      instr  <= '0;
      reg_a  <= '0;
      reg_b  <= '0;
      aluout <= '0;
      data   <= '0;
      for (int i = 0; i < NREG; i++) xreg[i] <= '0;
    end else begin
      case (state)
        S_IRLD: instr <= mem.memdout;
        S_DEC: begin
          reg_a <= rd_reg(rs1);
          reg_b <= rd_reg(rs2);
        end
        S_EXEC: begin
          if (is_br) begin
            pc <= br_taken ? pc_br : pc_plus4;
          end else if (is_jal) begin
            aluout <= 32'(pc_plus4);
            pc     <= pc_jal;
          end else begin
            aluout <= alu_res;
          end
        end
        S_MEM:   if (is_sw) pc <= pc_plus4;
        S_MWAIT: data <= mem.memdout;
        S_WB: begin
          if (rd != 5'd0) xreg[rd[RW-1:0]] <= is_lw ? data : aluout;
          if (!is_jal) pc <= pc_plus4;
        end
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_RV_CORE_INSTRET_EN
  logic retire;
  assign retire = (state == S_WB) || (state == S_EXEC && is_br) || (state == S_MEM && is_sw);

  // Retired-instruction counter; halting instructions never reach a retire point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instret <= '0;
    else if (retire) instret <= instret + 32'd1;
  end
`else
  assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_rv_core.sv
// Bench for multicycle_rv_core: directed program table with hand-derived
// results, cycle-exact corner sequences, and random forward-only programs
// checked against an instruction-level model with a unified memory.
module tb_multicycle_rv_core;
  localparam int ADDR_W = 8;
  localparam int NREG   = 32;
  localparam int A0_W   = 8;
  localparam int MW     = 256;
  localparam int PCM    = (1 << (ADDR_W + 2)) - 1;
  localparam int BUDGET = 3000;
  localparam logic [31:0] ECALL = 32'h00000073;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [A0_W-1:0] a0out;
  logic halted;
  logic [31:0] instret;

  multicycle_rv_core_if #(.ADDR_W(ADDR_W)) bus ();

  multicycle_rv_core #(.ADDR_W(ADDR_W), .NREG(NREG), .A0_W(A0_W)) dut (
    .clk(clk), .rst(rst), .mem(bus.master),
    .a0out(a0out), .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  logic [31:0] img [MW];
  logic [31:0] ram [MW];
  bit tb_load = 1'b0;

  always @(posedge clk) begin
    if (tb_load) ram <= img;
    else if (bus.memwe) ram[bus.memaddr] <= bus.memdin;
    bus.memdout <= ram[bus.memaddr];
  end

  int wr_cnt = 0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  always @(negedge clk) begin
    if (bus.memwe === 1'b1) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = bus.memaddr;
      wr_data = bus.memdin;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input int rd, input int rs1, input int imm);
    logic [31:0] im;
    im = imm;
    return {im[11:0], 5'(rs1), f3, 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rd, input int rs1, input int rs2);
    return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input int rs1, input int rs2, input int imm);
    logic [31:0] im;
    im = imm;
    return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input int rs1, input int rs2, input int imm);
    logic [31:0] im;
    im = imm;
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), f3, im[4:1], im[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input int rd, input int imm);
    logic [31:0] im;
    im = imm;
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(7'b0010011, 3'b000, rd, rs1, imm);
  endfunction
  function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
    return enc_i(7'b0000011, 3'b010, rd, rs1, imm);
  endfunction

  // ---------------- instruction-level reference model ----------------
  logic [31:0] m_mem [MW];
  logic [31:0] m_x [32];

  task automatic model_run(output int cyc, output int ret, output int nsw, output logic [31:0] a0);
    logic [31:0] pc, ins, a, b, immi, imms, immb, immj;
    int rd, rs1, rs2;
    bit done, taken;
    m_mem = img;
    for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
    pc = 0; cyc = 0; ret = 0; nsw = 0; done = 0;
    for (int step = 0; step < 4000 && !done; step++) begin
      ins  = m_mem[(pc >> 2) & (MW - 1)];
      rd   = int'(ins[11:7]);
      rs1  = int'(ins[19:15]);
      rs2  = int'(ins[24:20]);
      a    = m_x[rs1];
      b    = m_x[rs2];
      immi = {{20{ins[31]}}, ins[31:20]};
      imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      immj = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      done = 1;
      case (ins[6:0])
        7'b0010011: if (ins[14:12] == 3'd0) begin
          if (rd != 0) m_x[rd] = a + immi;
          pc = pc + 4; cyc += 5; done = 0;
        end
        7'b0110011: if (ins[14:12] == 3'd0 && (ins[31:25] == 7'h00 || ins[31:25] == 7'h20)) begin
          if (rd != 0) m_x[rd] = (ins[31:25] == 7'h20) ? a - b : a + b;
          pc = pc + 4; cyc += 5; done = 0;
        end
        7'b0000011: if (ins[14:12] == 3'd2) begin
          if (rd != 0) m_x[rd] = m_mem[((a + immi) >> 2) & (MW - 1)];
          pc = pc + 4; cyc += 7; done = 0;
        end
        7'b0100011: if (ins[14:12] == 3'd2) begin
          m_mem[((a + imms) >> 2) & (MW - 1)] = b;
          nsw++; pc = pc + 4; cyc += 5; done = 0;
        end
        7'b1100011: if (ins[14:12] == 3'd0 || ins[14:12] == 3'd1 || ins[14:12] == 3'd4) begin
          case (ins[14:12])
            3'd0:    taken = (a == b);
            3'd1:    taken = (a != b);
            default: taken = ($signed(a) < $signed(b));
          endcase
          pc = taken ? pc + immb : pc + 4;
          cyc += 4; done = 0;
        end
        7'b1101111: begin
          if (rd != 0) m_x[rd] = (pc + 4) & PCM;
          pc = pc + immj; cyc += 5; done = 0;
        end
        default: ;
      endcase
      pc = pc & PCM;
      if (done) cyc += 3;
      else ret++;
    end
    a0 = m_x[10];
  endtask

  // ---------------- run control ----------------
  task automatic load_and_reset();
    @(negedge clk);
    rst = 1'b1;
    tb_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_load = 1'b0;
  endtask

  // Releases rst at a falling edge and counts rising edges until halted.
  task automatic run_to_halt(output int n);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (n < BUDGET) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (halted) break;
    end
  endtask

  // ---------------- directed program table ----------------
  typedef struct {
    string       name;
    int          n;
    logic [31:0] code [24];
    int          dw_addr;
    logic [31:0] dw_val;
    logic [31:0] exp_a0;
    int          exp_cyc;
    int          exp_ret;
    int          exp_sw;
  } vec_t;

  vec_t vecs [6];
  int nv = 0;
  logic [31:0] sbuf [24];
  int nb = 0;

  task automatic emit(input logic [31:0] w);
    sbuf[nb] = w;
    nb++;
  endtask

  task automatic commit(input string name, input int dwa, input logic [31:0] dwv,
                        input logic [31:0] a0, input int cyc, input int ret, input int nsw);
    vecs[nv].name = name;
    vecs[nv].n = nb;
    for (int i = 0; i < 24; i++) vecs[nv].code[i] = (i < nb) ? sbuf[i] : 32'd0;
    vecs[nv].dw_addr = dwa;
    vecs[nv].dw_val = dwv;
    vecs[nv].exp_a0 = a0;
    vecs[nv].exp_cyc = cyc;
    vecs[nv].exp_ret = ret;
    vecs[nv].exp_sw = nsw;
    nv++;
    nb = 0;
  endtask

  task automatic image_from_vec(input int v);
    for (int i = 0; i < MW; i++) img[i] = 32'd0;
    for (int i = 0; i < vecs[v].n; i++) img[i] = vecs[v].code[i];
    img[vecs[v].dw_addr] = vecs[v].dw_val;
  endtask

  task automatic chk_instret(input string name, input int ret);
    logic [31:0] exp_ir;
`ifdef MULTICYCLE_RV_CORE_INSTRET_EN
    exp_ir = ret;
`else
    exp_ir = 32'd0;
`endif
    chk(name, instret, exp_ir);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w0, cyc, ret, nsw, bad;
    logic [31:0] ea0;

    // addi x10,x0,5 ; ecall
    emit(addi(10, 0, 5)); emit(ECALL);
    commit("addi_ecall", 200, 32'd0, 32'h05, 8, 1, 0);
    // lw x10,32(x0) ; ecall   with mem[8]=0x2A
    emit(lw(10, 0, 32)); emit(ECALL);
    commit("lw", 8, 32'h2A, 32'h2A, 10, 1, 0);
    // addi x5,x0,0x77 ; sw x5,16(x0) ; lw x10,16(x0) ; ecall
    emit(addi(5, 0, 32'h77)); emit(enc_s(0, 5, 16)); emit(lw(10, 0, 16)); emit(ECALL);
    commit("sw_lw", 200, 32'd0, 32'h77, 20, 3, 1);
    // iterative fib(10)
    emit(addi(1, 0, 0)); emit(addi(2, 0, 1)); emit(addi(3, 0, 10));
    emit(enc_r(7'h00, 4, 1, 2)); emit(addi(1, 2, 0)); emit(addi(2, 4, 0));
    emit(addi(3, 3, -1)); emit(enc_b(3'b001, 3, 0, -16));
    emit(addi(10, 1, 0)); emit(ECALL);
    commit("fib10", 200, 32'd0, 32'h37, 263, 54, 0);
    // x0 write ignored, then illegal opcode
    emit(addi(0, 0, 9)); emit(enc_r(7'h00, 10, 0, 0)); emit(32'h0000000B);
    commit("x0_illegal", 200, 32'd0, 32'h00, 13, 2, 0);
    // wrap to zero, taken beq, signed blt, jal link, sub
    emit(addi(1, 0, -1)); emit(addi(2, 0, 1)); emit(enc_r(7'h00, 3, 1, 2));
    emit(enc_b(3'b000, 3, 0, 8)); emit(addi(10, 0, 32'h11));
    emit(enc_b(3'b100, 1, 2, 8)); emit(addi(10, 0, 32'h22));
    emit(enc_j(6, 8)); emit(addi(10, 0, 32'h33));
    emit(enc_r(7'h20, 10, 6, 2)); emit(ECALL);
    commit("branch_jal", 200, 32'd0, 32'h1F, 36, 7, 0);

    // reset values
    image_from_vec(0);
    load_and_reset();
    chk("rst_memwe", {31'd0, bus.memwe}, 32'd0);
    chk("rst_memaddr", 32'(bus.memaddr), 32'd0);
    chk("rst_memdin", bus.memdin, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_a0out", 32'(a0out), 32'd0);

    for (int v = 0; v < nv; v++) begin
      image_from_vec(v);
      load_and_reset();
      w0 = wr_cnt;
      run_to_halt(n);
      chk({vecs[v].name, "_a0"}, 32'(a0out), vecs[v].exp_a0 & 32'hFF);
      chk({vecs[v].name, "_cycles"}, n, vecs[v].exp_cyc);
      chk({vecs[v].name, "_writes"}, wr_cnt - w0, vecs[v].exp_sw);
      chk_instret({vecs[v].name, "_instret"}, vecs[v].exp_ret);
      if (v == 2) begin
        chk("sw_addr", 32'(wr_addr), 32'd4);
        chk("sw_data", wr_data, 32'h77);
      end
      if (v == 4) begin
        w0 = wr_cnt;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("halt_sticky", {31'd0, halted}, 32'd1);
        chk("halt_no_writes", wr_cnt - w0, 32'd0);
        chk("halt_pc_frozen", 32'(bus.memaddr), 32'd2);
      end
    end

    // LW cycle-by-cycle: MEM address, then next fetch exactly 7 cycles in
    image_from_vec(1);
    load_and_reset();
    @(negedge clk);
    rst = 1'b0;
    chk("lw_fetch_addr", 32'(bus.memaddr), 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("lw_mem_addr", 32'(bus.memaddr), 32'd8);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lw_wb_addr", 32'(bus.memaddr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lw_next_fetch", 32'(bus.memaddr), 32'd1);
    chk("lw_a0_written", 32'(a0out), 32'h2A);

    // reset asserted during MWAIT of the LW, then a clean rerun
    image_from_vec(2);
    load_and_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    chk("mwait_mem_addr", 32'(bus.memaddr), 32'd4);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mwait_rst_memwe", {31'd0, bus.memwe}, 32'd0);
    chk("mwait_rst_memaddr", 32'(bus.memaddr), 32'd0);
    chk("mwait_rst_halted", {31'd0, halted}, 32'd0);
    chk("mwait_rst_instret", instret, 32'd0);
    run_to_halt(n);
    chk("mwait_rerun_cycles", n, 32'd20);
    chk("mwait_rerun_a0", 32'(a0out), 32'h77);

    // random forward-only programs against the instruction-level model
    for (int t = 0; t < 20; t++) begin
      int k, sel, rd, rs1, rs2, fs;
      logic [2:0] f3;
      for (int i = 0; i < MW; i++) img[i] = (i >= 64 && i < 128) ? $urandom : 32'd0;
      k = 0;
      for (int i = 0; i < 14; i++) begin
        sel = $urandom_range(0, 8);
        rd  = $urandom_range(0, 11);
        rs1 = $urandom_range(0, 11);
        rs2 = $urandom_range(0, 11);
        case (sel)
          0, 1, 2: img[k] = addi(rd, rs1, $urandom_range(0, 4095));
          3:       img[k] = enc_r(7'h00, rd, rs1, rs2);
          4:       img[k] = enc_r(7'h20, rd, rs1, rs2);
          5:       img[k] = enc_s(0, rs2, 256 + 4 * $urandom_range(0, 63) + $urandom_range(0, 3));
          6:       img[k] = lw(rd, rs1, $urandom_range(0, 4095));
          7: begin
            fs = $urandom_range(0, 2);
            f3 = (fs == 0) ? 3'b000 : (fs == 1) ? 3'b001 : 3'b100;
            img[k] = enc_b(f3, rs1, rs2, 8);
          end
          default: img[k] = enc_j(rd, 8);
        endcase
        k++;
      end
      for (int r = 1; r <= 11; r++) begin
        if (r != 10) begin
          img[k] = enc_r(7'h00, 10, 10, r);
          k++;
        end
      end
      img[k] = ECALL;
      model_run(cyc, ret, nsw, ea0);
      load_and_reset();
      w0 = wr_cnt;
      run_to_halt(n);
      chk($sformatf("rand%0d_a0", t), 32'(a0out), ea0 & 32'hFF);
      chk($sformatf("rand%0d_cycles", t), n, cyc);
      chk($sformatf("rand%0d_writes", t), wr_cnt - w0, nsw);
      chk_instret($sformatf("rand%0d_instret", t), ret);
      bad = 0;
      for (int i = 0; i < MW; i++) if (ram[i] !== m_mem[i]) bad++;
      chk($sformatf("rand%0d_mem_words_differing", t), bad, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
